// File: rtl/parity_checker.sv
// ---------------------------------------------------------------------------
// ParityChecker (module parity_checker)
//
// Serial 4-bit frame receiver. Each frame is three data bits a, b, c followed
// by a parity bit p. Each bit arrives on a cycle where din_valid is high, and
// idle cycles may fall between bits. The bit count doubles as the FSM state.
// When the parity bit arrives, the block registers the data bits and a
// parity-error flag, pulses frame_valid for one cycle and updates the
// frame/error counters.
//
// Parameters
//   ODD         : 0 = even parity over the 4 frame bits, 1 = odd parity
//
// Ports
//   clk         : rising-edge clock for all state
//   rst         : synchronous active-high reset
//   din         : serial frame bit, sampled when din_valid = 1
//   din_valid   : bit strobe, one frame bit per high cycle
//   flush       : discard any partial frame (wins over din_valid)
//   data        : last completed frame's {a,b,c}, a in bit 2
//   par_err     : parity-error flag of the last completed frame
//   frame_valid : one-cycle pulse after each completed frame
//   busy        : high while 1-3 bits of a frame are held
//   frame_cnt   : completed frames, wraps 255 -> 0
//   err_cnt     : frames with a parity error, saturates at 255
// ---------------------------------------------------------------------------
module parity_checker #(
    parameter int unsigned ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       din_valid,
    input  logic       flush,
    output logic [2:0] data,
    output logic       par_err,
    output logic       frame_valid,
    output logic       busy,
    output logic [7:0] frame_cnt,
    output logic [7:0] err_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GOT1 = 2'd1;
    localparam logic [1:0] GOT2 = 2'd2;
    localparam logic [1:0] GOT3 = 2'd3;

    localparam logic ODD_BIT = (ODD != 0) ? 1'b1 : 1'b0;

    logic [1:0] state_q,       state_d;
    logic [2:0] shreg_q,       shreg_d;
    logic [2:0] data_q,        data_d;
    logic       par_err_q,     par_err_d;
    logic       frame_valid_q, frame_valid_d;
    logic       busy_q,        busy_d;
    logic [7:0] frame_cnt_q,   frame_cnt_d;
    logic [7:0] err_cnt_q,     err_cnt_d;
    logic       frame_err;

    // Parity error for the frame that completes if this cycle's strobe is
    // the parity bit.
    assign frame_err = (shreg_q[2] ^ shreg_q[1] ^ shreg_q[0] ^ din) ^ ODD_BIT;

    // Next-state logic. Flush takes priority over a strobe. The shift
    // register is cleared whenever the FSM returns to IDLE, so it is always 0
    // in IDLE, and a flush while idle therefore changes nothing.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        data_d        = data_q;
        par_err_d     = par_err_q;
        frame_valid_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        err_cnt_d     = err_cnt_q;

        if (flush) begin
            state_d = IDLE;
            shreg_d = 3'b000;
        end else if (din_valid) begin
            if (state_q == GOT3) begin
                state_d       = IDLE;
                shreg_d       = 3'b000;
                data_d        = shreg_q;
                par_err_d     = frame_err;
                frame_valid_d = 1'b1;
                frame_cnt_d   = frame_cnt_q + 8'd1;
                if (frame_err && (err_cnt_q != 8'hFF)) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end else begin
                state_d = state_q + 2'd1;
                shreg_d = {shreg_q[1:0], din};
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State registers. Reset is synchronous and overrides flush and strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            shreg_q       <= 3'b000;
            data_q        <= 3'b000;
            par_err_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            frame_cnt_q   <= 8'd0;
            err_cnt_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            data_q        <= data_d;
            par_err_q     <= par_err_d;
            frame_valid_q <= frame_valid_d;
            busy_q        <= busy_d;
            frame_cnt_q   <= frame_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign data        = data_q;
    assign par_err     = par_err_q;
    assign frame_valid = frame_valid_q;
    assign busy        = busy_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: doc/parity_checker.md
PARITY_CHECKER -- requirements
Module: parity_checker

Interface
REQ-001 The block SHALL have parameter ODD, default 0, where 0 selects even parity over 4 frame bits (matching the 3-input XOR parity generator) and 1 selects odd.
REQ-002 Port clk, input, 1, the single rising-edge clock for all state.
REQ-003 Port rst, input, 1, the synchronous, active-high reset.
REQ-004 Port din, input, 1, the serial frame bit, sampled only when din_valid=1.
REQ-005 Port din_valid, input, 1, the bit strobe: one frame bit per cycle in which it is high.
REQ-006 Port flush, input, 1, which discards any partial frame.
REQ-007 Port data, output, 3, the last completed frame's data bits {a,b,c} with a in bit 2.
REQ-008 Port par_err, output, 1, the parity-error flag of the last completed frame.
REQ-009 Port frame_valid, output, 1, a one-cycle pulse marking a completed frame.
REQ-010 Port busy, output, 1, high while a partial frame (1-3 bits) is held.
REQ-011 Port frame_cnt, output, 8, the count of completed frames.
REQ-012 Port err_cnt, output, 8, the count of frames with par_err=1.

Function
REQ-013 A frame SHALL be 4 bits on consecutive din_valid strobes, in order a, b, c, p, with gaps of any length allowed between strobes.
REQ-014 The block SHALL keep a 2-bit bit counter (0..3) and a 3-bit shift register; the bit count is the FSM state: IDLE (0), GOT1 (1), GOT2 (2), GOT3 (3).
REQ-015 A strobe in IDLE, GOT1 or GOT2 SHALL shift din into the shift register LSB (shreg <= {shreg[1:0], din}) and advance the state by one.
REQ-016 A strobe in GOT3 SHALL take din as the parity bit, return the state to IDLE, and complete the frame.
REQ-017 On the clock edge that samples the parity bit, the block SHALL register data <= shreg and par_err <= (shreg[2]^shreg[1]^shreg[0]^din) ^ ODD.
REQ-018 On that same edge the block SHALL register frame_valid <= 1, so the pulse is visible in the cycle after the parity strobe (latency 1 cycle); frame_valid SHALL be 0 in every other cycle.
REQ-019 data and par_err SHALL hold their values until the next frame completes.
REQ-020 frame_cnt SHALL increment by 1 on each completed frame and wrap from 255 to 0.
REQ-021 err_cnt SHALL increment by 1 on each completed frame with computed par_err=1, and saturate at 255.
REQ-022 busy SHALL be a registered output equal to (state != IDLE).
REQ-023 When din_valid=0, the state, shift register and outputs SHALL hold, except that frame_valid returns to 0.
REQ-024 flush=1 SHALL force the state to IDLE and the shift register to 0 on the next edge, leaving data, par_err, frame_cnt and err_cnt unchanged.
REQ-025 When flush=1 and din_valid=1 in the same cycle, flush SHALL win: the bit is discarded, and if the state was GOT3 no frame completes and frame_valid stays 0.
REQ-026 flush=1 in IDLE SHALL have no effect.

Reset
REQ-027 rst=1 SHALL, on the next edge, set state=IDLE, shreg=0, data=0, par_err=0, frame_valid=0, busy=0, frame_cnt=0 and err_cnt=0.
REQ-028 rst SHALL take priority over flush and din_valid.
REQ-029 A rst asserted mid-frame SHALL abandon the partial frame, and the first strobe after reset SHALL be taken as bit a.

Verification
REQ-030 Scenario, ODD=0: strobes 1,0,1,0 on consecutive cycles -> one cycle later frame_valid=1, data=3'b101, par_err=0, frame_cnt=1, err_cnt=0.
REQ-031 Scenario: frame 1,1,1,0 -> par_err=1, err_cnt=1; then frame 1,1,1,1 -> par_err=0 with err_cnt still 1.
REQ-032 Scenario: all 8 {a,b,c} combinations each sent with the correct generator parity (a^b^c) -> 8 pulses, par_err=0 every time, frame_cnt=8; the same run with ODD=1 -> err_cnt=8.
REQ-033 Scenario: strobes 0,1 then flush, then frame 0,0,1,1 -> exactly one pulse, data=3'b001, par_err=0, busy=0 after the flush edge.
REQ-034 Scenario: 3 strobes, then a 4th strobe with flush=1 in the same cycle -> no pulse, frame_cnt unchanged, busy=0.
REQ-035 Scenario: 256 error frames, then rst mid-frame -> err_cnt=255 (saturated) and frame_cnt=0 (wrapped) before the reset, and every output 0 one cycle after rst.
